// File: rtl/cache_backing_mem.sv
// Backing-memory responder: one outstanding request, fixed LATENCY-cycle response.
// Writes commit and reads are captured on the acceptance edge; out-of-range addresses flag rsp_err.
module cache_backing_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_we,
    output logic                  rsp_err,
    output logic [1:0]            state_dbg
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid may drop while ready is 0, and response fields hold while rsp_valid waits for rsp_ready.

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int CW = $clog2(LATENCY + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]       CNT_INIT = CW'(LATENCY - 1);
    localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic                  accept;
    logic                  in_range;
    logic [IW-1:0]         idx;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign state_dbg = state;
    assign accept    = req_valid && req_ready;
    assign in_range  = ({1'b0, req_addr} < DEPTH_W);
    assign idx       = req_addr[IW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_we   <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_we   <= req_we;
                        rsp_err  <= !in_range;
                        rsp_data <= (!req_we && in_range) ? mem[idx] : '0;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    // Leaving at cnt==1 keeps the counter from ever wrapping below 1.
                    if (cnt <= CNT_ONE) begin
                        state <= RESP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The array is not reset; a write accepted before a reset stays committed.
    always_ff @(posedge clk) begin
        if (!rst && accept && req_we && in_range) mem[idx] <= req_wdata;
    end
endmodule

// File: tb/tb_cache_backing_mem.sv
// Bench for cache_backing_mem: a LATENCY=3 instance driven through a scoreboard,
// and a LATENCY=1 instance exercised back-to-back.
module tb_cache_backing_mem;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_we, rsp_err;
    logic [31:0] rsp_data;
    logic [1:0]  state_dbg;

    logic        q1_valid = 1'b0, q1_we = 1'b0, r1_ready = 1'b1;
    logic [7:0]  q1_addr = '0;
    logic [31:0] q1_wdata = '0;
    logic        q1_ready, r1_valid, r1_we, r1_err;
    logic [31:0] r1_data;
    logic [1:0]  st1;

    logic [33:0] exp_q[$];
    logic [31:0] model_mem [64];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    cache_backing_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_we(rsp_we), .rsp_err(rsp_err), .state_dbg(state_dbg)
    );

    cache_backing_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(q1_valid), .req_ready(q1_ready), .req_we(q1_we),
        .req_addr(q1_addr), .req_wdata(q1_wdata),
        .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_data(r1_data),
        .rsp_we(r1_we), .rsp_err(r1_err), .state_dbg(st1)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the handshake.
    task automatic xact(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        input int bp);
        logic        err;
        logic [31:0] exp_data;
        logic [31:0] held;
        logic [33:0] e;
        int          n;
        err      = (addr >= 8'd64);
        exp_data = (!we && !err) ? model_mem[addr[5:0]] : 32'd0;
        if (we && !err) model_mem[addr[5:0]] = wdata;
        exp_q.push_back({we, err, exp_data});
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            check("req_ready_busy", req_ready, 0);
            @(negedge clk);
            n++;
        end
        check("latency", n, LAT);
        held = rsp_data;
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = addr ^ 8'd1; req_wdata = ~wdata;
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_stable", rsp_data, held);
            check("bp_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        e = exp_q.pop_front();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_we", rsp_we, e[33]);
        check("rsp_err", rsp_err, e[32]);
        check("rsp_data", rsp_data, e[31:0]);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check(tag, rsp_valid, 0);
        end
        check({tag, "_ready"}, req_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_we", rsp_we, 0);
        check("rst_state", state_dbg, 0);
        check("rst1_ready", q1_ready, 1);

        // LATENCY=1 back-to-back with rsp_ready tied high.
        q1_valid = 1'b1; q1_we = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("l1_req_ready", q1_ready, (k % 2 == 0) ? 1 : 0);
            check("l1_rsp_valid", r1_valid, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 1) check("l1_rsp_we", r1_we, 1);
            q1_addr = 8'(k); q1_wdata = $urandom;
            @(negedge clk);
        end
        q1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        xact(1'b1, 8'd0, 32'h600D_CAFE, 0);
        xact(1'b1, 8'd5, 32'hDEAD_BEEF, 0);
        xact(1'b0, 8'd5, 32'h0, 0);
        xact(1'b0, 8'd5, 32'h0, 4);
        xact(1'b1, 8'd64, 32'h0000_1234, 0);
        xact(1'b0, 8'd64, 32'h0, 0);
        xact(1'b0, 8'd0, 32'h0, 0);

        // Reset one cycle after acceptance: response dropped, write kept.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd2; req_wdata = 32'hA5A5_A5A5;
        model_mem[2] = 32'hA5A5_A5A5;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midwait_state", state_dbg, 0);
        expect_quiet("midwait_quiet", 5);
        xact(1'b0, 8'd2, 32'h0, 0);

        // Reset on the same edge as a request: no acceptance, no write.
        xact(1'b1, 8'd7, 32'h0000_0011, 0);
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd7; req_wdata = 32'hBAD0_BAD0;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        expect_quiet("coinc_quiet", 4);
        xact(1'b0, 8'd7, 32'h0, 0);

        for (int t = 0; t < 24; t++) begin
            xact(1'($urandom_range(0, 1)), 8'($urandom_range(0, 70)), $urandom,
                 int'($urandom_range(0, 3)));
        end
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/cache_backing_mem.md
# cache_backing_mem

Backing-memory responder that sits on the memory side of the immediate cache and answers its fill and write-through requests. It accepts one request at a time over a valid/ready handshake. It holds the word array, and returns read data or a write acknowledge after a fixed, parameterised latency. It gives the cache a realistic slow-memory model and can also stand in as the on-chip data store.

## Interface
- ADDR_WIDTH, 8: request address width, same as the cache.
- DATA_WIDTH, 32: word width, same as the cache.
- DEPTH, 64: number of implemented words; addresses at or above DEPTH are out of range.
- LATENCY, 3: cycles from request acceptance to rsp_valid; legal range 1..15.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_data  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_we  out  1  echoes req_we of the transaction.
- rsp_err  out  1  address was out of range.

## Operation
- FSM states are IDLE, WAIT and RESP.
  - IDLE: req_ready=1. Accept on req_valid & req_ready. Go to RESP when LATENCY=1; otherwise go to WAIT with cnt=LATENCY-1.
  - WAIT: cnt decrements each cycle. Go to RESP on the cycle cnt reaches 1.
  - RESP: rsp_valid=1. Go to IDLE on rsp_ready.
- Only one transaction is outstanding at a time. req_ready=0 in WAIT and RESP, and requests offered then are not accepted.
- Write commit: the array is written on the acceptance edge. A later read therefore always returns the new data.
- Read capture: array[req_addr] is registered into the response register on the acceptance edge. rsp_data stays stable from rsp_valid until the handshake completes.
- Out-of-range address (req_addr >= DEPTH):
  - a write leaves the array unmodified;
  - a read returns rsp_data=0;
  - rsp_err=1 in both cases.
- rsp_we, rsp_err and rsp_data are registered at acceptance and held through RESP.
- Array contents are zero at time 0 and are not affected by rst.
- Counter width is $clog2(LATENCY+1). It must not wrap below 1.

## Timing
- Reset values: req_ready=1 in the cycle after rst; rsp_valid=0, rsp_data=0, rsp_we=0, rsp_err=0; state=IDLE; cnt=0.
- A request accepted at edge T gives rsp_valid=1 from cycle T+LATENCY. The response holds until the edge where rsp_ready=1.
- With rsp_ready tied high, the earliest next acceptance is at edge T+LATENCY+1. Throughput is therefore one transaction per LATENCY+1 cycles.
- rsp_ready is ignored outside RESP.
- req_valid may be withdrawn freely while req_ready=0; there is no requirement that it be held.
- Reset mid-transaction, in WAIT or RESP:
  - the transaction is dropped;
  - rsp_valid=0 in the next cycle;
  - a write accepted before the reset remains committed.
- rst high on the same edge as req_valid&req_ready: reset wins, with no acceptance and no write.
- Response handshake coincident with a new req_valid in RESP: the new request is not accepted that cycle. It is accepted in the following IDLE cycle.

## Test plan
- Reset, then idle: rst high for 2 cycles → req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0.
- Write then read, LATENCY=3:
  - write 0xDEADBEEF to address 5 → rsp_valid 3 cycles after acceptance with rsp_we=1, rsp_err=0, rsp_data=0;
  - read address 5 → rsp_data=0xDEADBEEF with rsp_we=0.
- Backpressure: read accepted with rsp_ready held 0 for 4 cycles → rsp_valid stays 1 and rsp_data is stable; req_ready stays 0; a req_valid offered meanwhile is not accepted.
- Out-of-range: write 0x1234 to address 64 and then read address 64 → rsp_err=1 both times, read rsp_data=0; address 0 still reads its previous value.
- Reset mid-WAIT: write 0xA5A5A5A5 to address 2, assert rst one cycle after acceptance → no rsp_valid; a later read of address 2 returns 0xA5A5A5A5.
- LATENCY=1 back-to-back: rsp_ready tied 1 and req_valid held 1 → responses every 2 cycles, and req_ready alternates 1/0.
